// File: rtl/fifo_param_if.sv
// Handshake, status and error signals of fifo_param grouped into one bundle.
// The peak port exists only when FIFO_PEAK_EN is defined.
interface fifo_param_if #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 3
);
   logic              wr_en;
   logic [DATA_W-1:0] data_in;
   logic              rd_en;
   logic [ADDR_W:0]   umbral_bajo;
   logic [ADDR_W:0]   umbral_alto;
   logic              err_clr;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic              overflow;
   logic              underflow;
`ifdef FIFO_PEAK_EN
   logic [ADDR_W:0]   peak;
`endif

   modport master (
      output wr_en, data_in, rd_en, umbral_bajo, umbral_alto, err_clr,
      input  data_out, rd_valid, count, full, empty, almost_full, almost_empty,
             overflow, underflow
`ifdef FIFO_PEAK_EN
      , input peak
`endif
   );

   modport slave (
      input  wr_en, data_in, rd_en, umbral_bajo, umbral_alto, err_clr,
      output data_out, rd_valid, count, full, empty, almost_full, almost_empty,
             overflow, underflow
`ifdef FIFO_PEAK_EN
      , output peak
`endif
   );
endinterface

// File: rtl/fifo_param.sv
// Synchronous FIFO with registered read data, threshold flags and sticky errors.
// Define FIFO_PEAK_EN to add the peak-occupancy tracker.
module fifo_param #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 3
) (
   input  logic         clk,
   input  logic         reset,
   fifo_param_if.slave  bus
);
   localparam int              DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count_q, count_next;
   logic [DATA_W-1:0] data_out_q;
   logic              rd_valid_q, overflow_q, underflow_q;
   logic              full, empty, rd_ok, wr_ok;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      full       = (count_q == DEPTH_C);
      empty      = (count_q == '0);
      rd_ok      = bus.rd_en && !empty;
      wr_ok      = bus.wr_en && (!full || rd_ok);
      count_next = count_q;
      if (wr_ok && !rd_ok)
         count_next = count_q + 1'b1;
      else if (rd_ok && !wr_ok)
         count_next = count_q - 1'b1;
   end

   // NOTE: the storage array has no reset; only pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (reset && wr_ok)
         mem[wr_ptr] <= bus.data_in;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) begin
            data_out_q <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 1'b1;
         end
         rd_valid_q  <= rd_ok;
         count_q     <= count_next;
         // A fresh error in the same cycle as err_clr keeps the flag set.
         overflow_q  <= (overflow_q  && !bus.err_clr) || (bus.wr_en && !wr_ok);
         underflow_q <= (underflow_q && !bus.err_clr) || (bus.rd_en && empty);
      end
   end

`ifdef FIFO_PEAK_EN
   logic [ADDR_W:0] peak_q;

   always_ff @(posedge clk) begin
      if (!reset || bus.err_clr)
         peak_q <= '0;
      else if (count_next > peak_q)
         peak_q <= count_next;
   end

   assign bus.peak = peak_q;
`endif

   assign bus.data_out     = data_out_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.count        = count_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= bus.umbral_alto);
   assign bus.almost_empty = (count_q <= bus.umbral_bajo);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule
